// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default geometry/timing parameters and a word-index to byte-address helper.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  // Default instruction-memory word-address width (2**8 = 256 words).
  localparam int DEF_ADDR_W   = 8;
  // Default number of cycles the CPU stays in reset after the last write.
  localparam int DEF_HOLD_CYC = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Word index -> word-aligned byte address.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Assembles a 32-bit word from a byte stream, most-significant byte first.
//
// Ports:
//   clk       : clock
//   reset     : asynchronous active-low reset
//   clr       : restart byte counting at the first byte of a word
//   byte_en   : a byte is transferred this cycle
//   byte_in   : byte being transferred
//   word_done : this transfer is the 4th byte of a word (combinational)
//   word_out  : complete word, valid while word_done is high
// -----------------------------------------------------------------------------
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word_out
);

  // Only the first three bytes need storage; the fourth is taken straight from
  // byte_in so the word is available on the same edge it completes.
  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (byte_en) begin
      shift_reg <= {shift_reg[15:0], byte_in};
      cnt_reg   <= cnt_reg + 2'd1;   // wraps 3 -> 0 at the end of each word
    end
  end

  assign word_done = byte_en && (cnt_reg == 2'd3);
  assign word_out  = {shift_reg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program byte stream into instruction memory while holding the CPU in
// reset, then releases the CPU HOLD_CYC cycles after the last word is written.
//
// Ports:
//   clk        : clock, all state changes on rising edge
//   reset      : asynchronous active-low reset
//   start      : single-cycle pulse that begins a load
//   word_count : number of 32-bit words to load (sampled on accepted start)
//   in_valid   : a byte is present on in_data
//   in_data    : program bytes, MSB of each word first
//   in_ready   : a byte is accepted this cycle (RECV only)
//   imem_we    : instruction-memory write strobe
//   imem_addr  : word-aligned byte address of the write
//   imem_wdata : assembled instruction word
//   cpu_reset  : active-high CPU reset
//   busy       : load in progress (RECV, WRITE, HOLD)
//   done       : load complete, held until the next accepted start
//   err        : single-cycle pulse on a start with word_count == 0
//   checksum   : XOR of all words written in the current load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  // Index/count are one bit wider than ADDR_W so a full-memory load
  // (word_count = 2**ADDR_W) is representable and the index never wraps.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [CNT_W-1:0]   word_idx_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        checksum_reg;
  logic               err_reg;

  logic               idle_or_done;
  logic               start_ok;
  logic               start_bad;
  logic               byte_en;
  logic               word_done;
  logic [31:0]        word_out;
  logic [CNT_W-1:0]   idx_inc;
  logic               last_word;

  assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign start_ok     = start && idle_or_done && (word_count != '0);
  assign start_bad    = start && idle_or_done && (word_count == '0);
  assign byte_en      = in_valid && (state_reg == ST_RECV);
  assign idx_inc      = word_idx_reg + 1'b1;
  assign last_word    = (idx_inc == word_cnt_reg);

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .byte_en   (byte_en),
    .byte_in   (in_data),
    .word_done (word_done),
    .word_out  (word_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      word_idx_reg <= '0;
      hold_cnt_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      checksum_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= start_bad;

      if (start_ok) begin
        word_cnt_reg <= word_count;
        word_idx_reg <= '0;
        checksum_reg <= '0;
      end

      // Latch the write beat one cycle ahead so WRITE drives registered values,
      // which then simply hold outside WRITE.
      if (word_done) begin
        wdata_reg <= word_out;
        addr_reg  <= word_byte_addr(32'(word_idx_reg));
      end

      if (state_reg == ST_WRITE) begin
        checksum_reg <= checksum_reg ^ wdata_reg;
        word_idx_reg <= idx_inc;
        if (last_word) begin
          hold_cnt_reg <= HOLD_W'(HOLD_CYC);
        end
      end

      if (state_reg == ST_HOLD) begin
        hold_cnt_reg <= hold_cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_reset  = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (start_ok) state_next = ST_RECV;
      end
      ST_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_done) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        if (!last_word)         state_next = ST_RECV;
        else if (HOLD_CYC == 0) state_next = ST_DONE;
        else                    state_next = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        // Counter was loaded with HOLD_CYC on entry; the cycle seeing 1 is the last.
        if (hold_cnt_reg == HOLD_W'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start_ok) state_next = ST_RECV;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign checksum   = checksum_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A monitor captures every write beat;
// each scenario task compares the captured writes, checksum and handshake
// timing against values computed directly from the program table.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW   = 8;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;

  logic [63:0] wr_q[$];     // {addr, data} of every observed write
  logic [31:0] prog_q[$];   // program for the next load

  imem_loader #(.ADDR_W(AW), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    if (err === 1'b1) err_seen++;
  end

  // 31-word insertion-sort image (first word 34080000, last 1000FFFF).
  task automatic load_sort_prog();
    logic [31:0] img [31] = '{
      32'h34080000, 32'h34090001, 32'h340A001F, 32'h112A0014,
      32'h00095080, 32'h3C011001, 32'h002A0821, 32'h8C2B0000,
      32'h2128FFFF, 32'h0500000B, 32'h00086080, 32'h3C011001,
      32'h002C0821, 32'h8C2D0000, 32'h016D702A, 32'h15C00006,
      32'hAC2D0004, 32'h2108FFFF, 32'h0810000A, 32'h00000000,
      32'h00086080, 32'h3C011001, 32'h002C0821, 32'hAC2B0004,
      32'h21290001, 32'h08100003, 32'h00000000, 32'h340A001F,
      32'h00000000, 32'h00000000, 32'h1000FFFF
    };
    prog_q.delete();
    foreach (img[i]) prog_q.push_back(img[i]);
  endtask

  // Start a load of prog_q, stream it with in_valid asserted pct% of cycles,
  // optionally pulse a spurious start at byte inject_at, then check the write
  // sequence, checksum, and the CPU-reset release timing.
  task automatic run_load(input int pct, input int inject_at, input string name);
    int n = prog_q.size();
    int k = 0;
    int guard = 0;
    int bad_rst = 0;
    int err0;
    bit injected = 0;
    bit v;
    logic [31:0] w;
    logic [31:0] exp_sum = '0;

    wr_q.delete();
    err0 = err_seen;
    @(negedge clk);
    start = 1'b1;
    word_count = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    word_count = '0;

    n_cmp++;
    if ({busy, cpu_reset, done, in_ready} !== 4'b1101) begin
      n_err++;
      $display("FAIL %s start_state: busy/cpu_reset/done/in_ready=%b required 1101", name,
               {busy, cpu_reset, done, in_ready});
    end

    while (k < 4*n && guard < 20000) begin
      v = ($urandom_range(99) < pct);
      w = prog_q[k/4];
      in_valid = v;
      in_data  = 8'(w >> (8*(3-(k%4))));
      if (inject_at >= 0 && k == inject_at && !injected) begin
        start = 1'b1;
        word_count = (AW+1)'(5);
        injected = 1;
      end else begin
        start = 1'b0;
      end
      if (cpu_reset !== 1'b1) bad_rst++;
      if (v && in_ready === 1'b1) k++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;

    n_cmp++;
    if (k != 4*n) begin
      n_err++;
      $display("FAIL %s stream_timeout: bytes accepted=%0d required %0d", name, k, 4*n);
    end

    guard = 0;
    while (wr_q.size() < n && guard < 200) begin
      if (cpu_reset !== 1'b1) bad_rst++;
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (wr_q.size() != n || imem_we !== 1'b1) begin
      n_err++;
      $display("FAIL %s write_count: writes=%0d we=%b required %0d and we=1", name,
               wr_q.size(), imem_we, n);
    end

    for (int j = 0; j < HOLD; j++) begin
      @(negedge clk);
      if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) bad_rst++;
    end
    n_cmp++;
    if (bad_rst != 0) begin
      n_err++;
      $display("FAIL %s cpu_reset_hold: bad samples=%0d required 0", name, bad_rst);
    end

    @(negedge clk);
    n_cmp++;
    if ({cpu_reset, done, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL %s release: cpu_reset/done/busy=%b required 010", name, {cpu_reset, done, busy});
    end

    for (int i = 0; i < n; i++) begin
      exp_sum ^= prog_q[i];
      n_cmp++;
      if (i >= wr_q.size() || wr_q[i] !== {32'(i*4), prog_q[i]}) begin
        n_err++;
        $display("FAIL %s write[%0d]: got %h required %h", name, i,
                 (i < wr_q.size()) ? wr_q[i] : 64'hx, {32'(i*4), prog_q[i]});
      end
    end

    n_cmp++;
    if (checksum !== exp_sum) begin
      n_err++;
      $display("FAIL %s checksum: got %h required %h", name, checksum, exp_sum);
    end

    n_cmp++;
    if (err_seen != err0) begin
      n_err++;
      $display("FAIL %s no_err: err pulses=%0d required 0", name, err_seen - err0);
    end

    $display("load %s: words=%0d valid%%=%0d writes=%0d checksum=%h", name, n, pct,
             wr_q.size(), checksum);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_reset, in_ready, imem_we, busy, done, err} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_async_ctrl: got %b required 100000",
               {cpu_reset, in_ready, imem_we, busy, done, err});
    end
    n_cmp++;
    if ({imem_addr, imem_wdata, checksum} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_async_data: got %h required 0", {imem_addr, imem_wdata, checksum});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cpu_reset, in_ready, imem_we, busy, done, err} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_idle: got %b required 100000",
               {cpu_reset, in_ready, imem_we, busy, done, err});
    end
    $display("reset: cpu_reset=%b busy=%b done=%b", cpu_reset, busy, done);
  endtask

  // Zero-count start: err for exactly one cycle, nothing else moves.
  // exp_cpu_reset/exp_done describe the state the start is issued in.
  task automatic test_zero_count(input logic exp_cpu_reset, input logic exp_done, input string name);
    int err_hi = 0;
    int bad = 0;
    int wr0 = wr_q.size();
    @(negedge clk);
    start = 1'b1;
    word_count = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (err === 1'b1) err_hi++;
      if (cpu_reset !== exp_cpu_reset || done !== exp_done || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (err_hi != 1) begin
      n_err++;
      $display("FAIL %s err_pulse: cycles high=%0d required 1", name, err_hi);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s state_kept: bad samples=%0d required 0", name, bad);
    end
    n_cmp++;
    if (wr_q.size() != wr0) begin
      n_err++;
      $display("FAIL %s no_write: writes=%0d required %0d", name, wr_q.size(), wr0);
    end
    $display("zero_count %s: err cycles=%0d cpu_reset=%b done=%b", name, err_hi, cpu_reset, done);
  endtask

  task automatic test_full_load();
    load_sort_prog();
    run_load(100, -1, "sort_full_rate");
    n_cmp++;
    if (wr_q.size() != 31 || wr_q[0] !== {32'h0, 32'h34080000} || wr_q[30] !== {32'h78, 32'h1000FFFF}) begin
      n_err++;
      $display("FAIL sort_endpoints: first=%h last=%h required 0000000034080000 / 000000781000ffff",
               (wr_q.size() > 0) ? wr_q[0] : 64'hx, (wr_q.size() > 30) ? wr_q[30] : 64'hx);
    end
  endtask

  task automatic test_second_load();
    prog_q.delete();
    prog_q.push_back(32'hDEADBEEF);
    prog_q.push_back(32'h00000001);
    run_load(100, -1, "two_word");
    n_cmp++;
    if (checksum !== 32'hDEADBEEE) begin
      n_err++;
      $display("FAIL two_word_checksum: got %h required deadbeee", checksum);
    end
    test_zero_count(1'b0, 1'b1, "in_done");
  endtask

  task automatic test_gappy_load();
    load_sort_prog();
    run_load(50, -1, "sort_gappy");
  endtask

  task automatic test_restart_ignored();
    load_sort_prog();
    run_load(80, 6, "restart_ignored");
  endtask

  task automatic test_reset_midload();
    int k = 0;
    int guard = 0;
    int wr0;
    load_sort_prog();
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    word_count = (AW+1)'(31);
    @(negedge clk);
    start = 1'b0;
    while (k < 10 && guard < 100) begin
      in_valid = 1'b1;
      in_data = 8'(prog_q[k/4] >> (8*(3-(k%4))));
      if (in_ready === 1'b1) k++;
      @(negedge clk);
      guard++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, busy, cpu_reset, imem_we, done} !== 5'b00100) begin
      n_err++;
      $display("FAIL midload_reset_async: in_ready/busy/cpu_reset/we/done=%b required 00100",
               {in_ready, busy, cpu_reset, imem_we, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    wr0 = wr_q.size();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (wr_q.size() != wr0 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL midload_abandon: new writes=%0d in_ready=%b busy=%b cpu_reset=%b required 0/0/0/1",
               wr_q.size() - wr0, in_ready, busy, cpu_reset);
    end
    $display("reset_midload: bytes before reset=%0d writes after=%0d", k, wr_q.size() - wr0);
    run_load(100, -1, "after_reset");
  endtask

  task automatic test_full_memory();
    prog_q.delete();
    for (int i = 0; i < (1 << AW); i++) prog_q.push_back($urandom);
    run_load(70, -1, "full_memory");
  endtask

  initial begin
    test_reset();
    test_zero_count(1'b1, 1'b0, "in_idle");
    test_full_load();
    test_second_load();
    test_gappy_load();
    test_restart_ignored();
    test_reset_midload();
    test_full_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
